// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tdm_demux_pkg;

  // Frame assembly states: waiting for a sof word, filling slots, frame on output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } tdm_state_t;

  // Slot counter width; never narrower than one bit, so a 1-channel build still has a counter.
  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_1ton.sv
// 1-to-N demux that steers one channel word to a single slot register write.
// Latency: combinational.
// Backpressure: none; en gates every write-enable low.
// Ports: d (word), sel (slot index), en (write strobe) ->
//        we (one-hot slot write-enables), q (d replicated into every slot lane).
module demux_1ton
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int SW   = slot_w(N_CH)
) (
  input  logic [W-1:0]      d,
  input  logic [SW-1:0]     sel,
  input  logic              en,
  output logic [N_CH-1:0]   we,
  output logic [N_CH*W-1:0] q
);

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    assign we[i]        = en && (sel == SW'(i));
    assign q[i*W +: W]  = d;
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: assembles a serial slot stream into a parallel N_CH-word frame.
// Latency: out_valid rises one cycle after the last slot word is accepted.
// Backpressure: while a frame is held, in_ready follows out_ready; a sof word may enter in the release cycle.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_sof/in_ready serial side;
//        out_data/out_valid/out_ready frame side (slot k at [k*W +: W]); err_sync framing-error pulse.
// Build option TDM_DEMUX_PARITY_EN: in_data gains an even-parity MSB and out_perr reports per-slot parity errors.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic [W:0]        in_data,
`else
  input  logic [W-1:0]      in_data,
`endif
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef TDM_DEMUX_PARITY_EN
  output logic [N_CH-1:0]   out_perr,
`endif
  output logic              err_sync
);

  localparam int            SW   = slot_w(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  tdm_state_t        state;
  logic [SW-1:0]     slot;
  logic              in_xfer;
  logic              out_xfer;
  logic              wr_en;
  logic [SW-1:0]     wr_sel;
  logic [W-1:0]      wr_word;
  logic [N_CH-1:0]   we;
  logic [N_CH*W-1:0] wr_rep;

  // A held frame blocks input unless it is being released this very cycle.
  assign in_ready = !rst && ((state != HOLD) || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A sof word always lands in slot 0 (new frame, early sof, or zero-bubble restart from HOLD).
  // A non-sof word is only stored while collecting; elsewhere it is dropped.
  assign wr_en   = in_xfer && (in_sof || (state == COLLECT));
  assign wr_sel  = in_sof ? '0 : slot;
  assign wr_word = in_data[W-1:0];

  demux_1ton #(
    .N_CH (N_CH),
    .W    (W),
    .SW   (SW)
  ) u_demux (
    .d   (wr_word),
    .sel (wr_sel),
    .en  (wr_en),
    .we  (we),
    .q   (wr_rep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (we[i]) out_data[i*W +: W] <= wr_rep[i*W +: W];
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity over all W+1 bits: a set XOR means the word arrived corrupted.
  // Starting a frame wipes the flags left over from the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_perr <= '0;
    end else if (wr_en) begin
      if (in_sof) out_perr <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (we[i]) out_perr[i] <= ^in_data;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      out_valid <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      err_sync <= 1'b0;
      case (state)
        // HOLD shares the IDLE handling: any input transfer there implies the frame is released.
        IDLE, HOLD: begin
          if ((state == HOLD) && out_xfer && !in_xfer) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (in_xfer) begin
            if (in_sof) begin
              if (N_CH == 1) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                slot      <= '0;
              end else begin
                state     <= COLLECT;
                out_valid <= 1'b0;
                slot      <= SW'(1);
              end
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              slot      <= '0;
              err_sync  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (in_xfer) begin
            if (in_sof) begin
              // Early sof: the partial frame is abandoned, this word is slot 0 of a fresh one.
              slot     <= SW'(1);
              err_sync <= 1'b1;
            end else if (slot == LAST) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              slot      <= '0;
            end else begin
              slot <= slot + SW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          slot      <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
`ifdef TDM_DEMUX_PARITY_EN
  logic [W:0]        in_data;
  logic [N_CH-1:0]   out_perr;
`else
  logic [W-1:0]      in_data;
`endif
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic [N_CH*W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              err_sync;

  int checks   = 0;
  int failures = 0;
  bit par_bad  = 0;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef TDM_DEMUX_PARITY_EN
    .out_perr  (out_perr),
`endif
    .err_sync  (err_sync)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: a list of words gathered for the current frame and a held frame.
  logic [W-1:0]      m_buf [N_CH];
  int                m_cnt   = 0;
  bit                m_held  = 0;
  bit                m_err   = 0;
  logic [N_CH*W-1:0] m_frame = '0;

  function automatic bit m_ready(input bit o);
    return !m_held || o;
  endfunction

  task automatic m_update(input bit r, input bit v, input bit s, input logic [W-1:0] d, input bit o);
    bit acc;
    if (r) begin
      m_cnt = 0; m_held = 0; m_err = 0;
      return;
    end
    acc   = v && m_ready(o);
    m_err = 0;
    if (m_held && o) m_held = 0;
    if (acc) begin
      if (s) begin
        if (m_cnt > 0) m_err = 1;
        m_buf[0] = d;
        m_cnt = 1;
      end else if (m_cnt > 0) begin
        m_buf[m_cnt] = d;
        m_cnt++;
      end else begin
        m_err = 1;
      end
      if (m_cnt == N_CH) begin
        m_held = 1;
        m_cnt  = 0;
        for (int k = 0; k < N_CH; k++) m_frame[k*W +: W] = m_buf[k];
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, sample in_ready before the edge, outputs at the next negedge.
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d, input bit o,
                      output bit rdy_s);
    rst = r; in_valid = v; in_sof = s; out_ready = o;
`ifdef TDM_DEMUX_PARITY_EN
    in_data = {(^d) ^ par_bad, d};
`else
    in_data = d;
`endif
    #1;
    rdy_s = in_ready;
    chk("in_ready", in_ready, !r && m_ready(o));
    @(posedge clk);
    m_update(r, v, s, d, o);
    @(negedge clk);
    chk("out_valid", out_valid, m_held);
    chk("err_sync", err_sync, m_err);
    if (m_held) chk("out_data", out_data, m_frame);
  endtask

  typedef struct {
    bit                v;
    bit                s;
    logic [W-1:0]      d;
    bit                o;
    bit                e_rdy;
    bit                e_vld;
    bit                e_err;
    logic [N_CH*W-1:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit v, input bit s, input logic [W-1:0] d, input bit o,
                      input bit e_rdy, input bit e_vld, input bit e_err, input logic [N_CH*W-1:0] e_dat);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.o = o;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_err = e_err; t.e_dat = e_dat;
    tbl.push_back(t);
  endtask

  initial begin
    bit rs;
    bit rr, vv, ss, oo;
    logic [W-1:0] dd;

    // Reset state.
    step(1, 0, 0, 8'h00, 1, rs);
    step(1, 0, 0, 8'h00, 1, rs);
    chk("rst_in_ready", rs, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);

    // Basic frame, released immediately.
    addv(1, 1, 8'h11, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h22, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h33, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h44, 1, 1, 1, 0, 32'h44332211);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0);
    // Same frame held for 5 cycles while a sof word waits.
    addv(1, 1, 8'h11, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h22, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h33, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h44, 1, 1, 1, 0, 32'h44332211);
    for (int i = 0; i < 5; i++) addv(1, 1, 8'hAA, 0, 0, 1, 0, 32'h44332211);
    // Release accepts AA with zero bubble; then back-to-back frames.
    addv(1, 1, 8'hAA, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hAB, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hAC, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hAD, 1, 1, 1, 0, 32'hADACABAA);
    addv(1, 1, 8'hB0, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hB1, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hB2, 1, 1, 0, 0, 0);
    addv(1, 0, 8'hB3, 1, 1, 1, 0, 32'hB3B2B1B0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0);
    // Early sof.
    addv(1, 1, 8'h01, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h02, 1, 1, 0, 0, 0);
    addv(1, 1, 8'h10, 1, 1, 0, 1, 0);
    addv(1, 0, 8'h20, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h30, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h40, 1, 1, 1, 0, 32'h40302010);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0);
    // Non-sof word in IDLE, then a clean frame.
    addv(1, 0, 8'h55, 1, 1, 0, 1, 0);
    addv(1, 1, 8'h61, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h62, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h63, 1, 1, 0, 0, 0);
    addv(1, 0, 8'h64, 1, 1, 1, 0, 32'h64636261);
    // Non-sof word in the release cycle is dropped with an error.
    addv(1, 0, 8'h99, 1, 1, 0, 1, 0);
    addv(0, 0, 8'h00, 1, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].o, rs);
      chk($sformatf("tbl%0d_rdy", i), rs, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_vld", i), out_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_err", i), err_sync, tbl[i].e_err);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), out_data, tbl[i].e_dat);
    end

    // Reset mid-frame, then a clean frame with no stale slots and no error.
    step(0, 1, 1, 8'hE1, 1, rs);
    step(0, 1, 0, 8'hE2, 1, rs);
    step(1, 1, 0, 8'hE3, 1, rs);
    chk("midrst_rdy", rs, 0);
    chk("midrst_err", err_sync, 0);
    chk("midrst_vld", out_valid, 0);
    step(0, 1, 1, 8'h0A, 1, rs);
    chk("post_rst_err", err_sync, 0);
    step(0, 1, 0, 8'h0B, 1, rs);
    par_bad = 1;
    step(0, 1, 0, 8'h0C, 1, rs);
    par_bad = 0;
    step(0, 1, 0, 8'h0D, 1, rs);
    chk("post_rst_vld", out_valid, 1);
    chk("post_rst_dat", out_data, 32'h0D0C0B0A);
    chk("post_rst_err2", err_sync, 0);
`ifdef TDM_DEMUX_PARITY_EN
    chk("perr_slot2", out_perr, 4'b0100);
`endif
    step(0, 0, 0, 8'h00, 1, rs);
    chk("post_rst_release", out_valid, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      vv = ($urandom_range(0, 9) < 8);
      ss = (m_cnt == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      oo = ($urandom_range(0, 9) < 7);
      dd = W'($urandom);
      step(rr, vv, ss, dd, oo, rs);
`ifdef TDM_DEMUX_PARITY_EN
      if (m_held) chk("rnd_perr", out_perr, '0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
